// File: rtl/fp8_e4m3_pkg.sv
// rtl/fp8_e4m3_pkg.sv - shared E4M3 constants, reducer state encoding and operand decode helpers
package fp8_e4m3_pkg;

    localparam int         E4M3_BIAS = 7;
    localparam logic [7:0] E4M3_MAX  = 8'h7F;
    localparam int         ACC_FRAC  = 18;

    typedef enum logic [1:0] {
        S_ACCUM,
        S_DRAIN,
        S_CONVERT,
        S_OUTPUT
    } state_t;

    // Significand with the hidden bit made explicit; subnormals have it clear.
    function automatic logic [3:0] e4m3_sig(input logic [6:0] x);
        return {|x[6:3], x[2:0]};
    endfunction

    // Effective exponent: subnormals share the scale of exponent 1.
    function automatic logic [3:0] e4m3_eexp(input logic [6:0] x);
        return (x[6:3] == 4'd0) ? 4'd1 : x[6:3];
    endfunction

endpackage

// File: rtl/fp8_e4m3_fix_round.sv
// rtl/fp8_e4m3_fix_round.sv - signed fixed-point (LSB 2^-18) to E4M3 conversion with RNE and saturation
module fp8_e4m3_fix_round
    import fp8_e4m3_pkg::*;
#(
    parameter int ACC_W = 45
) (
    input  logic [ACC_W-1:0] acc_i,
    output logic [7:0]       data_o,
    output logic             sat_o
);

    // Leading one at or above this bit position means a normal result (exp field >= 1).
    localparam int P_MIN = ACC_FRAC + 1 - E4M3_BIAS;

    logic             sign;
    logic [ACC_W-1:0] mag;
    logic [ACC_W-1:0] norm;
    logic [2:0]       mant;
    logic             guard;
    logic             sticky;
    logic             rnd;
    int               p;
    int               pe;
    int               code;

    // Normalise the magnitude, round to 3 mantissa bits, then clamp.
    // Subnormals are handled by pinning the normalisation point at P_MIN so the
    // hidden bit lands as zero and the mantissa is simply the 2^-9 quantisation.
    // The rounded code is built as {exp, mant} + rnd so a mantissa carry rolls into exp.
    always_comb begin
        sign = acc_i[ACC_W-1];
        mag  = sign ? -acc_i : acc_i;
        p    = 0;
        for (int i = 0; i < ACC_W; i++) begin
            if (mag[i]) begin
                p = i;
            end
        end
        pe     = (p < P_MIN) ? P_MIN : p;
        norm   = mag << (ACC_W - 1 - pe);
        mant   = norm[ACC_W-2 -: 3];
        guard  = norm[ACC_W-5];
        sticky = |norm[ACC_W-6:0];
        rnd    = guard & (sticky | mant[0]);
        code   = norm[ACC_W-1] ? ((pe - ACC_FRAC + E4M3_BIAS) * 8) : 0;
        code   = code + int'(mant) + int'(rnd);
        data_o = 8'h00;
        sat_o  = 1'b0;
        if (code > int'(E4M3_MAX)) begin
            data_o = {sign, E4M3_MAX[6:0]};
            sat_o  = 1'b1;
        end else if (code != 0) begin
            data_o = {sign, code[6:0]};
        end
    end

endmodule

// File: rtl/fp8_e4m3_dot_accum.sv
// rtl/fp8_e4m3_dot_accum.sv - streaming E4M3 dot product with exact wide accumulation and single final rounding
module fp8_e4m3_dot_accum
    import fp8_e4m3_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_sat
);

    localparam int ACC_W = 37 + LEN_W;

    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [7:0]       out_data_q;
    logic             out_sat_q;
    logic [LEN_W-1:0] cnt_q;
    logic             drain_q;

    logic             v1_q;
    logic             sgn_q;
    logic [7:0]       prod_q;
    logic [4:0]       sh_q;
    logic             v2_q;
    logic [ACC_W-1:0] term_q;
    logic [ACC_W-1:0] acc_q;

    logic             in_hs;
    logic             out_hs;
    logic             is_last;
    logic [3:0]       sa;
    logic [3:0]       sb;
    logic [3:0]       ea;
    logic [3:0]       eb;
    logic [7:0]       prod_d;
    logic [4:0]       sh_d;
    logic [ACC_W-1:0] mag_d;
    logic [ACC_W-1:0] term_d;
    logic [ACC_W-1:0] acc_d;
    logic [7:0]       conv_data;
    logic             conv_sat;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    assign in_hs   = in_valid && in_ready_q;
    assign out_hs  = out_valid_q && out_ready;
    assign is_last = in_last || (cnt_q == '1);

    // Operand decode, exact product and alignment shift; then place into the accumulator frame.
    always_comb begin
        sa     = e4m3_sig(in_a[6:0]);
        sb     = e4m3_sig(in_b[6:0]);
        ea     = e4m3_eexp(in_a[6:0]);
        eb     = e4m3_eexp(in_b[6:0]);
        prod_d = {4'b0000, sa} * {4'b0000, sb};
        sh_d   = {1'b0, ea} + {1'b0, eb} - 5'd2;
        mag_d  = {{(ACC_W-8){1'b0}}, prod_q} << sh_q;
        term_d = sgn_q ? -mag_d : mag_d;
        acc_d  = acc_q + term_q;
    end

    // P1 (decode/multiply) and P2 (shift/negate) pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            sgn_q  <= 1'b0;
            prod_q <= 8'h00;
            sh_q   <= 5'd0;
            v2_q   <= 1'b0;
            term_q <= '0;
        end else begin
            v1_q <= in_hs;
            if (in_hs) begin
                sgn_q  <= in_a[7] ^ in_b[7];
                prod_q <= prod_d;
                sh_q   <= sh_d;
            end
            v2_q <= v1_q;
            if (v1_q) begin
                term_q <= term_d;
            end
        end
    end

    // P3 accumulator; cleared once the result has been taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (out_hs) begin
            acc_q <= '0;
        end else if (v2_q) begin
            acc_q <= acc_d;
        end
    end

    fp8_e4m3_fix_round #(
        .ACC_W (ACC_W)
    ) u_round (
        .acc_i  (acc_q),
        .data_o (conv_data),
        .sat_o  (conv_sat)
    );

    // Vector sequencing: accept, drain the two pipeline stages, convert once, hold until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_ACCUM;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_sat_q   <= 1'b0;
            cnt_q       <= '0;
            drain_q     <= 1'b0;
        end else begin
            case (state_q)
                S_ACCUM: begin
                    in_ready_q <= !(in_hs && is_last);
                    if (in_hs) begin
                        cnt_q <= cnt_q + LEN_W'(1);
                        if (is_last) begin
                            drain_q <= 1'b0;
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_q) begin
                        state_q <= S_CONVERT;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                S_CONVERT: begin
                    out_data_q  <= conv_data;
                    out_sat_q   <= conv_sat;
                    out_valid_q <= 1'b1;
                    state_q     <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    if (out_hs) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= S_ACCUM;
                    end
                end
                default: begin
                    state_q <= S_ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp8_e4m3_dot_accum.sv
// tb/tb_fp8_e4m3_dot_accum.sv - self-checking bench for the E4M3 dot-product reducer
module tb_fp8_e4m3_dot_accum;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = 8'h00;
    logic [7:0] in_b = 8'h00;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_sat;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];

    fp8_e4m3_dot_accum #(.LEN_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic real pow2(input int n);
        real r;
        r = 1.0;
        if (n >= 0) begin
            for (int i = 0; i < n; i++) r = r * 2.0;
        end else begin
            for (int i = 0; i < -n; i++) r = r / 2.0;
        end
        return r;
    endfunction

    // Real value of an E4M3 code: bias 7, exp 0 subnormal (frac * 2^-9), no specials.
    function automatic real e4m3_val(input logic [7:0] c);
        real m;
        int  e;
        int  f;
        e = int'(c[6:3]);
        f = int'(c[2:0]);
        if (e == 0) m = $itor(f) * pow2(-9);
        else        m = (1.0 + $itor(f) / 8.0) * pow2(e - 7);
        return c[7] ? -m : m;
    endfunction

    // Exact real dot product, then nearest E4M3 by table search with ties to the even code.
    // 496 is the midpoint between 480 and the next (unrepresentable, even) step 512.
    task automatic ref_dot(output logic [7:0] code, output logic sat);
        real s;
        real ax;
        real d;
        real bd;
        int  best;
        bit  neg;
        s = 0.0;
        foreach (qa[i]) s = s + e4m3_val(qa[i]) * e4m3_val(qb[i]);
        neg = (s < 0.0);
        ax  = neg ? -s : s;
        if (ax >= 496.0) begin
            code = {neg, 7'h7F};
            sat  = 1'b1;
        end else begin
            best = 0;
            bd   = ax;
            for (int c = 1; c < 128; c++) begin
                d = ax - e4m3_val(8'(c));
                if (d < 0.0) d = -d;
                if (d < bd || (d == bd && (c % 2) == 0 && (best % 2) == 1)) begin
                    best = c;
                    bd   = d;
                end
            end
            sat  = 1'b0;
            code = (best == 0) ? 8'h00 : {neg, 7'(best)};
        end
    endtask

    function automatic logic [7:0] rnd_code();
        logic [7:0] c;
        c = 8'($urandom);
        if ($urandom_range(0, 3) != 0) begin
            c = {c[7], 4'($urandom_range(0, 9)), c[2:0]};
        end
        return c;
    endfunction

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input logic last, input bit gaps);
        int wait_n;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                in_a     = 8'($urandom);
                in_b     = 8'($urandom);
                in_last  = 1'($urandom);
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        wait_n   = 0;
        while (in_ready !== 1'b1 && wait_n < 50) begin
            @(posedge clk);
            #1;
            wait_n++;
        end
        chk("accept_timeout", 32'(wait_n < 50), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
        in_last  = 1'($urandom);
    endtask

    task automatic run_vec(input string tag, input bit use_model, input logic [7:0] xd, input logic xs,
                           input int hold, input bit no_last, input bit gaps);
        logic [7:0] ed;
        logic       es;
        int         lat;
        for (int i = 0; i < qa.size(); i++) begin
            send_pair(qa[i], qb[i], !no_last && (i == qa.size() - 1), gaps);
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd3);
        if (use_model) begin
            ref_dot(ed, es);
        end else begin
            ed = xd;
            es = xs;
        end
        chk({tag, "_data"}, 32'(out_data), 32'(ed));
        chk({tag, "_sat"}, 32'(out_sat), 32'(es));
        chk({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_data"}, 32'(out_data), 32'(ed));
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_valid_cleared"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int n;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h00);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        qa = '{8'h38}; qb = '{8'h38};
        run_vec("one_x_one", 0, 8'h38, 1'b0, 0, 0, 0);
        qa = '{8'h38, 8'h38, 8'h38, 8'h38}; qb = '{8'h40, 8'h40, 8'h40, 8'h40};
        run_vec("four_times_two", 0, 8'h50, 1'b0, 1, 0, 0);
        qa = '{8'h38, 8'hB8}; qb = '{8'h38, 8'h38};
        run_vec("cancel_to_zero", 0, 8'h00, 1'b0, 0, 0, 1);
        qa = '{8'h38, 8'h18}; qb = '{8'h38, 8'h38};
        run_vec("tie_to_even", 0, 8'h38, 1'b0, 0, 0, 0);
        qa = '{8'h7F}; qb = '{8'h7F};
        run_vec("sat_pos", 0, 8'h7F, 1'b1, 0, 0, 0);
        qa = '{8'hFF}; qb = '{8'h7F};
        run_vec("sat_neg", 0, 8'hFF, 1'b1, 0, 0, 0);
        qa = '{8'h01}; qb = '{8'h38};
        run_vec("subnormal_min", 0, 8'h01, 1'b0, 0, 0, 0);
        qa = '{8'h01}; qb = '{8'h30};
        run_vec("subnormal_tie", 0, 8'h00, 1'b0, 0, 0, 0);
        qa = '{8'h38}; qb = '{8'h40};
        run_vec("backpressure", 0, 8'h40, 1'b0, 5, 0, 0);

        send_pair(8'h7F, 8'h7F, 1'b0, 0);
        send_pair(8'h7F, 8'h7F, 1'b0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'h00);
        chk("midrst_out_sat", 32'(out_sat), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_in_ready_back", 32'(in_ready), 32'd1);
        qa = '{8'h40}; qb = '{8'h38};
        run_vec("after_midrst", 0, 8'h40, 1'b0, 0, 0, 0);

        qa.delete(); qb.delete();
        for (int k = 0; k < 256; k++) begin
            qa.push_back(8'h38);
            qb.push_back(8'h38);
        end
        run_vec("implicit_last", 0, 8'h78, 1'b0, 0, 1, 0);

        for (int v = 0; v < 24; v++) begin
            n = $urandom_range(1, 6);
            qa.delete(); qb.delete();
            for (int k = 0; k < n; k++) begin
                qa.push_back(rnd_code());
                qb.push_back(rnd_code());
            end
            run_vec($sformatf("rand%0d", v), 1, 8'h00, 1'b0, $urandom_range(0, 2), 0, 1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
